// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared sizing, index/word types and the XZR index for the LEGv8 register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_file_pkg;

  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_word_t;

  // X31 reads as zero and swallows writes.
  localparam reg_idx_t XZR_IDX = 5'd31;

endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: read/write bus between the datapath and the register file.
// Latency: reads are combinational, writes land on the next rising clk edge.
// Backpressure: none; a write is accepted every cycle.
interface reg_file_if;
  import reg_file_pkg::*;

  reg_idx_t    read_reg1;
  reg_idx_t    read_reg2;
  reg_idx_t    write_reg;
  reg_word_t   write_data;
  logic        reg_write;
  reg_word_t   read_data1;
  reg_word_t   read_data2;
  logic [31:0] write_count;

  // Datapath side: drives indices and write data, consumes operands.
  modport master (
    output read_reg1, read_reg2, write_reg, write_data, reg_write,
    input  read_data1, read_data2, write_count
  );

  // Register file side.
  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, reg_write,
    output read_data1, read_data2, write_count
  );

endinterface

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one read port - index mux, XZR/unmapped zero forcing, optional write-through (REG_FILE_BYPASS_EN).
// Latency: zero, purely combinational.
// Backpressure: none.
module reg_file_rd_port
  import reg_file_pkg::*;
(
  input  reg_idx_t  rd_idx,
  input  reg_word_t regs [NUM_REGS],
  input  logic      wr_en,
  input  reg_idx_t  wr_idx,
  input  reg_word_t wr_data,
  output reg_word_t rd_data
);

  logic idx_mapped;
  logic bypass_hit;

  // Indices past the last physical register only exist when NUM_REGS is shrunk.
  if (NUM_REGS < (1 << ADDR_W)) begin : g_partial_map
    assign idx_mapped = (32'(rd_idx) < 32'(NUM_REGS));
  end else begin : g_full_map
    assign idx_mapped = 1'b1;
  end

`ifdef REG_FILE_BYPASS_EN
  // wr_en already excludes reset cycles; the XZR case is handled by the zero forcing below.
  assign bypass_hit = wr_en && (wr_idx == rd_idx);
`else
  logic unused_wr;
  assign unused_wr  = ^{wr_en, wr_idx, wr_data};
  assign bypass_hit = 1'b0;
`endif

  // XZR and unmapped indices win over both stored data and the bypass.
  always_comb begin
    rd_data = '0;
    if (idx_mapped && (rd_idx != XZR_IDX)) begin
      rd_data = bypass_hit ? wr_data : regs[rd_idx];
    end
  end

endmodule

// File: rtl/reg_file.sv
// reg_file: 32 x 64-bit LEGv8 register file, two async read ports, one sync write port, X31 = XZR (REG_FILE_BYPASS_EN adds write-through).
// Latency: reads zero cycles; writes visible the cycle after the rising edge.
// Backpressure: none; write_count tallies committed writes and wraps.
module reg_file
  import reg_file_pkg::*;
(
  input  logic clk,
  input  logic reset,
  reg_file_if.slave bus
);

  reg_word_t   regs [NUM_REGS];
  logic [31:0] write_count_q;
  logic        wr_mapped;
  logic        wr_commit;
  logic        wr_live;

  if (NUM_REGS < (1 << ADDR_W)) begin : g_partial_map
    assign wr_mapped = (32'(bus.write_reg) < 32'(NUM_REGS));
  end else begin : g_full_map
    assign wr_mapped = 1'b1;
  end

  // Reset is handled in the sequential block; it has priority over a commit.
  assign wr_commit = bus.reg_write && (bus.write_reg != XZR_IDX) && wr_mapped;
  assign wr_live   = bus.reg_write && !reset;

  // Storage and commit counter: reset clears everything and drops any write in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      write_count_q <= '0;
    end else if (wr_commit) begin
      regs[bus.write_reg] <= bus.write_data;
      write_count_q       <= write_count_q + 32'd1;
    end
  end

  assign bus.write_count = write_count_q;

  reg_file_rd_port u_rd1 (
    .rd_idx  (bus.read_reg1),
    .regs    (regs),
    .wr_en   (wr_live),
    .wr_idx  (bus.write_reg),
    .wr_data (bus.write_data),
    .rd_data (bus.read_data1)
  );

  reg_file_rd_port u_rd2 (
    .rd_idx  (bus.read_reg2),
    .regs    (regs),
    .wr_en   (wr_live),
    .wr_idx  (bus.write_reg),
    .wr_data (bus.write_data),
    .rd_data (bus.read_data2)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file against an array model of the LEGv8 register file.
// Latency: expectations are sampled on the falling edge after inputs change.
// Backpressure: none.
module tb_reg_file;

  logic clk;
  logic reset;

  reg_file_if bus ();

  reg_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [31:0] wc;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] mdl [32];
  logic [31:0] mdl_cnt;
  int          errors = 0;
  int          checks = 0;

  // Architectural read as seen during a cycle whose write has not yet landed.
  function automatic logic [63:0] model_read(int idx, bit rst, bit we, int wr, logic [63:0] wd);
    if (idx == 31) return 64'h0;
`ifdef REG_FILE_BYPASS_EN
    if (we && !rst && wr == idx) return wd;
`endif
    return mdl[idx];
  endfunction

  // One cycle of stimulus: drive, record what the outputs must be now, then advance the model past the next edge.
  task automatic step(input string name, input bit rst, input bit we, input int wr,
                      input logic [63:0] wd, input int r1, input int r2);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = rst;
    bus.reg_write  = we;
    bus.write_reg  = 5'(wr);
    bus.write_data = wd;
    bus.read_reg1  = 5'(r1);
    bus.read_reg2  = 5'(r2);
    e.name = name;
    e.rd1  = model_read(r1, rst, we, wr, wd);
    e.rd2  = model_read(r2, rst, we, wr, wd);
    e.wc   = mdl_cnt;
    sb_q.push_back(e);
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 64'h0;
      mdl_cnt = 32'd0;
    end else if (we && wr != 31) begin
      mdl[wr] = wd;
      mdl_cnt = mdl_cnt + 32'd1;
    end
  endtask

  task automatic rd(input string name, input int r1, input int r2);
    step(name, 1'b0, 1'b0, 0, 64'h0, r1, r2);
  endtask

  // Monitor: every cycle carrying an expectation is compared on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (bus.read_data1 !== e.rd1) begin
        errors++;
        $display("FAIL %s read_data1: got %h expected %h", e.name, bus.read_data1, e.rd1);
      end
      checks++;
      if (bus.read_data2 !== e.rd2) begin
        errors++;
        $display("FAIL %s read_data2: got %h expected %h", e.name, bus.read_data2, e.rd2);
      end
      checks++;
      if (bus.write_count !== e.wc) begin
        errors++;
        $display("FAIL %s write_count: got %0d expected %0d", e.name, bus.write_count, e.wc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 64'h0;
    mdl_cnt        = 32'd0;
    reset          = 1'b1;
    bus.reg_write  = 1'b0;
    bus.write_reg  = '0;
    bus.write_data = '0;
    bus.read_reg1  = '0;
    bus.read_reg2  = '0;
    repeat (2) @(posedge clk);

    // Reset state.
    rd("reset_read", 5, 31);

    // Basic write then read back.
    step("write_x5", 1'b0, 1'b1, 5, 64'hDEAD_BEEF_0123_4567, 5, 0);
    rd("read_x5", 5, 5);

    // XZR swallows writes and reads zero.
    step("xzr_write", 1'b0, 1'b1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 5, 31);
    rd("xzr_read", 31, 31);

    // Disabled write leaves X7 alone.
    step("we_off", 1'b0, 1'b0, 7, 64'h55, 7, 7);
    rd("x7_kept", 7, 5);

    // Same-cycle read of the write target.
    step("x9_init", 1'b0, 1'b1, 9, 64'h10, 0, 0);
    step("x9_rdw", 1'b0, 1'b1, 9, 64'h20, 9, 9);
    rd("x9_after", 9, 31);

    // Fill X0..X30 with their indices.
    for (int i = 0; i < 31; i++) step("fill", 1'b0, 1'b1, i, 64'(i), i, 30 - i);
    for (int i = 0; i < 32; i += 2) rd("fill_read", i, i + 1);

    // Reset together with a write: write dropped, everything cleared.
    step("reset_wr", 1'b1, 1'b1, 3, 64'hAA, 3, 4);
    for (int i = 0; i < 32; i += 2) rd("post_reset", i, i + 1);

    // Randomized traffic, with occasional resets and XZR writes.
    for (int n = 0; n < 400; n++) begin
      bit          rst;
      bit          we;
      int          wr;
      int          r1;
      int          r2;
      logic [63:0] wd;
      rst = ($urandom_range(0, 59) == 0);
      we  = ($urandom_range(0, 3) != 0);
      wr  = ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 31);
      wd  = {$urandom, $urandom};
      r1  = ($urandom_range(0, 3) == 0) ? wr : $urandom_range(0, 31);
      r2  = ($urandom_range(0, 3) == 0) ? wr : $urandom_range(0, 31);
      step("random", rst, we, wr, wd, r1, r2);
    end
    rd("final", 0, 1);

    // Let the monitor drain the last expectation.
    repeat (3) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
